// File: rtl/calc_sched.sv
// -----------------------------------------------------------------------------
// calc_sched
//   Two-requester scheduler in front of a shared, single-cycle integer
//   calculator (int_calc). One request is in flight at a time. Requests are
//   arbitrated round-robin, latched on acceptance, and executed on the calculator.
//   The result is then held on the response channel until it is accepted.
//
//   Ops: 000 add, 001 sub, 010 mul, 011 div, 100 mod (unsigned, modulo 2^W).
//        div/mod by zero -> error, data all-ones, no calculator cycle.
//        110/111 -> error, data 0.
//        101 -> power when CALC_SCHED_POW_EN is defined, otherwise error.
//
//   Configuration macro: CALC_SCHED_POW_EN
//        Defined  : op 101 computes opa^k with k = opb[EXPW-1:0]. It uses k
//                   calculator mul cycles, and k == 0 answers 1 at once.
//        Undefined: op 101 is an error, and no accumulator/counter is built.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN_valid/ready         request handshake, N = 0,1
//   reqN_op/opa/opb          request operation and operands
//   resp_valid/ready         response handshake
//   resp_id                  requester that was served
//   resp_data/resp_err       result and error flag
//   calc_op/opa/opb          drive to the shared calculator (0 outside EXEC)
//   calc_out                 calculator result, settles within the cycle
// -----------------------------------------------------------------------------
module calc_sched #(
    parameter int W    = 64,
    parameter int EXPW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_opa,
    input  logic [W-1:0] req0_opb,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_opa,
    input  logic [W-1:0] req1_opb,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_data,
    output logic         resp_err,
    output logic [2:0]   calc_op,
    output logic [W-1:0] calc_opa,
    output logic [W-1:0] calc_opb,
    input  logic [W-1:0] calc_out
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    // The exponent field must fit inside the operand.
    if (EXPW < 1 || EXPW > W) begin : g_expw_check
        $error("calc_sched: EXPW must be in 1..W");
    end

    state_t         state_reg;
    logic           run_reg;    // set on the first edge after reset release
    logic           last_reg;   // requester served last (1 -> req0 wins next tie)
    logic           resp_valid_reg;
    logic           resp_id_reg;
    logic [W-1:0]   resp_data_reg;
    logic           resp_err_reg;
    logic [2:0]     calc_op_reg;
    logic [W-1:0]   calc_opa_reg;
    logic [W-1:0]   calc_opb_reg;
`ifdef CALC_SCHED_POW_EN
    logic            pow_reg;   // current EXEC sequence is a power op
    logic [EXPW-1:0] cnt_reg;   // remaining mul cycles after the current one
    logic [EXPW-1:0] sel_k;
`endif

    logic           grant0;
    logic           grant1;
    logic           accept;
    logic           sel_id;
    logic [2:0]     sel_op;
    logic [W-1:0]   sel_opa;
    logic [W-1:0]   sel_opb;
    logic           exec_done;

    // Round-robin grant. The grant only matters in IDLE. Before the first
    // edge after reset, no ready is shown.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_reg);
        grant1     = req1_valid && (!req0_valid || !last_reg);
        req0_ready = run_reg && (state_reg == IDLE) && grant0;
        req1_ready = run_reg && (state_reg == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        sel_id     = req1_ready;
        sel_op     = sel_id ? req1_op  : req0_op;
        sel_opa    = sel_id ? req1_opa : req0_opa;
        sel_opb    = sel_id ? req1_opb : req0_opb;
`ifdef CALC_SCHED_POW_EN
        sel_k      = sel_opb[EXPW-1:0];
        exec_done  = !pow_reg || (cnt_reg == '0);
`else
        exec_done  = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            run_reg        <= 1'b0;
            last_reg       <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= 1'b0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            calc_op_reg    <= '0;
            calc_opa_reg   <= '0;
            calc_opb_reg   <= '0;
`ifdef CALC_SCHED_POW_EN
            pow_reg        <= 1'b0;
            cnt_reg        <= '0;
`endif
        end else begin
            run_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        last_reg    <= sel_id;
                        resp_id_reg <= sel_id;
                        case (sel_op)
                            3'd0, 3'd1, 3'd2: begin
                                calc_op_reg  <= sel_op;
                                calc_opa_reg <= sel_opa;
                                calc_opb_reg <= sel_opb;
                                state_reg    <= EXEC;
                            end
                            3'd3, 3'd4: begin
                                if (sel_opb == '0) begin
                                    // Divide by zero is answered without using the calculator.
                                    resp_data_reg  <= '1;
                                    resp_err_reg   <= 1'b1;
                                    resp_valid_reg <= 1'b1;
                                    state_reg      <= RESP;
                                end else begin
                                    calc_op_reg  <= sel_op;
                                    calc_opa_reg <= sel_opa;
                                    calc_opb_reg <= sel_opb;
                                    state_reg    <= EXEC;
                                end
                            end
`ifdef CALC_SCHED_POW_EN
                            3'd5: begin
                                if (sel_k == '0) begin
                                    resp_data_reg  <= {{(W-1){1'b0}}, 1'b1};
                                    resp_err_reg   <= 1'b0;
                                    resp_valid_reg <= 1'b1;
                                    state_reg      <= RESP;
                                end else begin
                                    // calc_opa_reg is the running product. It starts at 1.
                                    pow_reg      <= 1'b1;
                                    cnt_reg      <= sel_k - 1'b1;
                                    calc_op_reg  <= 3'd2;
                                    calc_opa_reg <= {{(W-1){1'b0}}, 1'b1};
                                    calc_opb_reg <= sel_opa;
                                    state_reg    <= EXEC;
                                end
                            end
`endif
                            default: begin
                                resp_data_reg  <= '0;
                                resp_err_reg   <= 1'b1;
                                resp_valid_reg <= 1'b1;
                                state_reg      <= RESP;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        resp_data_reg  <= calc_out;
                        resp_err_reg   <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        calc_op_reg    <= '0;
                        calc_opa_reg   <= '0;
                        calc_opb_reg   <= '0;
                        state_reg      <= RESP;
`ifdef CALC_SCHED_POW_EN
                        pow_reg        <= 1'b0;
`endif
                    end
`ifdef CALC_SCHED_POW_EN
                    else begin
                        calc_opa_reg <= calc_out;
                        cnt_reg      <= cnt_reg - 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        resp_id_reg    <= 1'b0;
                        resp_data_reg  <= '0;
                        resp_err_reg   <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign resp_data  = resp_data_reg;
    assign resp_err   = resp_err_reg;
    assign calc_op    = calc_op_reg;
    assign calc_opa   = calc_opa_reg;
    assign calc_opb   = calc_opb_reg;

endmodule

// File: tb/tb_calc_sched.sv
// -----------------------------------------------------------------------------
// tb_calc_sched
//   Testbench for calc_sched. It models the shared calculator and predicts each
//   transaction from the operation rules: who is granted, the result, the error
//   flag and the latency. It prints one line per transaction.
// -----------------------------------------------------------------------------
module tb_calc_sched;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [2:0]  req0_op;
    logic [63:0] req0_opa, req0_opb;
    logic        req1_valid, req1_ready;
    logic [2:0]  req1_op;
    logic [63:0] req1_opa, req1_opb;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [63:0] resp_data;
    logic [2:0]  calc_op;
    logic [63:0] calc_opa, calc_opb, calc_out;

    int checks = 0;
    int errors = 0;
    int last_id;   // requester served last, as the bench tracks it

    calc_sched #(.W(64), .EXPW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_opa(req0_opa), .req0_opb(req0_opb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_opa(req1_opa), .req1_opb(req1_opb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err),
        .calc_op(calc_op), .calc_opa(calc_opa), .calc_opb(calc_opb),
        .calc_out(calc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared int_calc: combinational, unsigned, modulo 2^64.
    always_comb begin
        calc_out = '0;
        case (calc_op)
            3'd0: calc_out = calc_opa + calc_opb;
            3'd1: calc_out = calc_opa - calc_opb;
            3'd2: calc_out = calc_opa * calc_opb;
            3'd3: calc_out = (calc_opb == 0) ? '1 : calc_opa / calc_opb;
            3'd4: calc_out = (calc_opb == 0) ? '1 : calc_opa % calc_opb;
            default: calc_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Predicts the result, error flag and cycles from acceptance to resp_valid.
    function automatic void ref_model(input logic [2:0] op, input logic [63:0] a,
                                      input logic [63:0] b, output logic [63:0] d,
                                      output logic e, output int lat);
        int k;
        d = '0; e = 1'b0; lat = 1;
        k = int'(b[7:0]);
        case (op)
            3'd0: d = a + b;
            3'd1: d = a - b;
            3'd2: d = a * b;
            3'd3: if (b == 0) begin d = '1; e = 1'b1; lat = 0; end else d = a / b;
            3'd4: if (b == 0) begin d = '1; e = 1'b1; lat = 0; end else d = a % b;
`ifdef CALC_SCHED_POW_EN
            3'd5: begin
                d = 64'd1;
                for (int i = 0; i < k; i++) d = d * a;
                lat = k;
            end
`endif
            default: begin d = '0; e = 1'b1; lat = 0; end
        endcase
    endfunction

    // One complete transaction. Entered at posedge+1 with the DUT in IDLE.
    // hold < 0 picks a random number of resp_ready-low cycles.
    task automatic txn(input int hold, input bit scramble);
        int          win, cyc, lat, h;
        logic [2:0]  op, exp_cop;
        logic [63:0] a, b, ed, exp_cob;
        logic        ee;
        #1;
        if (!req0_valid && !req1_valid) return;
        if (req0_valid && req1_valid) win = 1 - last_id;
        else                          win = req1_valid ? 1 : 0;
        check("grant0", 64'(req0_ready), 64'(win == 0));
        check("grant1", 64'(req1_ready), 64'(win == 1));
        op = win ? req1_op  : req0_op;
        a  = win ? req1_opa : req0_opa;
        b  = win ? req1_opb : req0_opb;
        ref_model(op, a, b, ed, ee, lat);
        exp_cop = (op == 3'd5) ? 3'd2 : op;
        exp_cob = (op == 3'd5) ? a : b;
        @(posedge clk); #1;
        last_id = win;
        if (scramble) begin
            if (win == 1) begin
                req1_op = 3'($urandom); req1_opa = {$urandom, $urandom}; req1_opb = {$urandom, $urandom};
            end else begin
                req0_op = 3'($urandom); req0_opa = {$urandom, $urandom}; req0_opb = {$urandom, $urandom};
            end
        end
        cyc = 0;
        while (!resp_valid && cyc < 400) begin
            check("exec_op", 64'(calc_op), 64'(exp_cop));
            check("exec_opb", calc_opb, exp_cob);
            check("exec_rdy", 64'(req0_ready | req1_ready), 64'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("resp_id", 64'(resp_id), 64'(win));
        check("resp_data", resp_data, ed);
        check("resp_err", 64'(resp_err), 64'(ee));
        $display("txn id=%0d op=%0d a=%h b=%h data=%h err=%0d lat=%0d", win, op, a, b,
                 resp_data, resp_err, cyc);
        h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
        for (int i = 0; i < h; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_data", resp_data, ed);
            check("hold_id", 64'(resp_id), 64'(win));
            check("hold_err", 64'(resp_err), 64'(ee));
            check("hold_rdy", 64'(req0_ready | req1_ready), 64'd0);
            check("hold_calc", 64'(calc_op) | calc_opa | calc_opb, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("ack_valid", 64'(resp_valid), 64'd0);
    endtask

    task automatic set_req(input int n, input logic v, input logic [2:0] op,
                           input logic [63:0] a, input logic [63:0] b);
        if (n == 0) begin req0_valid = v; req0_op = op; req0_opa = a; req0_opb = b; end
        else        begin req1_valid = v; req1_op = op; req1_opa = a; req1_opb = b; end
    endtask

    initial begin
        rst_n = 1'b0;
        resp_ready = 1'b0;
        set_req(0, 1'b1, 3'd1, 64'd3, 64'd5);
        set_req(1, 1'b1, 3'd1, 64'd3, 64'd5);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(req0_ready | req1_ready), 64'd0);
        check("rst_resp", 64'(resp_valid | resp_id | resp_err) | resp_data, 64'd0);
        check("rst_calc", 64'(calc_op) | calc_opa | calc_opb, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_pre_edge", 64'(req0_ready | req1_ready), 64'd0);
        @(posedge clk); #1;
        last_id = 1;

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) txn(0, 1'b0);

        // req0 add 5 + 7.
        set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
        set_req(0, 1'b1, 3'd0, 64'd5, 64'd7);
        txn(0, 1'b0);

        // req1 div by zero, then mod 17 % 5.
        set_req(0, 1'b0, 3'd0, 64'd0, 64'd0);
        set_req(1, 1'b1, 3'd3, 64'd9, 64'd0);
        txn(0, 1'b0);
        set_req(1, 1'b1, 3'd4, 64'd17, 64'd5);
        txn(0, 1'b0);

        // Power (or error in the default build), then k == 0 through opb = 0x100.
        set_req(1, 1'b1, 3'd5, 64'd3, 64'd4);
        txn(0, 1'b0);
        set_req(1, 1'b1, 3'd5, 64'd3, 64'h100);
        txn(0, 1'b0);
        set_req(1, 1'b1, 3'd6, 64'd1, 64'd1);
        txn(0, 1'b0);

        // resp_ready held low for 5 cycles.
        set_req(1, 1'b0, 3'd0, 64'd0, 64'd0);
        set_req(0, 1'b1, 3'd2, 64'd11, 64'd13);
        txn(5, 1'b1);

        // Reset pulse in the middle of EXEC.
        set_req(0, 1'b1, 3'd2, 64'd6, 64'd7);
        #1;
        @(posedge clk); #1;
        check("mid_exec_op", 64'(calc_op), 64'd2);
        rst_n = 1'b0;
        #1;
        check("abort_calc", 64'(calc_op) | calc_opa | calc_opb, 64'd0);
        check("abort_resp", 64'(resp_valid | resp_err | resp_id) | resp_data, 64'd0);
        check("abort_rdy", 64'(req0_ready | req1_ready), 64'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("no_stale", 64'(resp_valid), 64'd0);
        end
        last_id = 1;

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            logic [2:0]  op0, op1;
            logic [63:0] b0, b1;
            int          vv;
            vv  = int'($urandom_range(1, 3));
            op0 = 3'($urandom);
            op1 = 3'($urandom);
            b0  = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom, $urandom};
            b1  = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom, $urandom};
            if (op0 == 3'd5) b0[7:0] = 8'($urandom_range(0, 8));
            if (op1 == 3'd5) b1[7:0] = 8'($urandom_range(0, 8));
            set_req(0, vv[0], op0, {$urandom, $urandom}, b0);
            set_req(1, vv[1], op1, {$urandom, $urandom}, b1);
            txn(-1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
